mb_down_seq: RTL and testbench
==============================

Name: mb_down_seq

Overview:
- Read-side index sequencer that pairs with the modulo-13 up-counting write index.
- After a start pulse it walks the buffer in reverse, MOD-1 down to 0.
- Each index is presented to a downstream consumer under a valid/ready handshake.
- Signals done when index 0 has been consumed; sits between the write-side buffer and the downstream datapath.

Parameters:
- MOD, 13, number of buffer entries; index range 0..MOD-1.
- W, 4, index width; elaboration error if 2**W < MOD or MOD < 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a reverse pass
- abort  input  1  cancel the current pass
- ready  input  1  consumer accepts the current idx this cycle
- idx  output  W  current read index (registered)
- valid  output  1  idx is valid for consumption
- last  output  1  valid && idx==0
- zero  output  1  idx==0 (combinational from idx)
- done  output  1  one-cycle pulse after the final index is accepted
- busy  output  1  state != IDLE

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, idx=0, valid=0, done=0. Derived outputs: busy=0, last=0, zero=1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 && abort=0 at a posedge -> next cycle state=RUN, idx=MOD-1, valid=1.
  - Latency from start to first valid is 1 cycle.
- RUN:
  - valid=1 throughout.
  - Transfer occurs on a posedge with valid && ready.
  - Transfer with idx>0 -> idx decrements by 1.
  - Transfer with idx==0 -> state=DONE, valid=0, idx stays 0.
  - ready=0 -> idx and valid hold (no skipped or duplicated index).
  - start is ignored while in RUN.
- DONE: done=1 for exactly one cycle, then state=IDLE; start is ignored in DONE.
- abort: in any state, abort=1 at a posedge -> state=IDLE, idx=0, valid=0, done=0 next cycle. abort has priority over start and over a simultaneous transfer.
- Pass length: one pass transfers exactly MOD indices (MOD-1..0) regardless of stall pattern.
- Arithmetic:
  - Decrement is modulo-free; idx never underflows because 0 triggers exit (or reload, see optional feature).
  - Reload value is MOD-1 truncated to W bits.
- Reset mid-pass: immediate return to reset values; no done pulse is emitted.
- Outputs valid, done and idx are registered; last, zero and busy are combinational decodes of registered state.

Optional Feature:
- Macro: MB_DOWN_SEQ_WRAP_EN.
- Defined:
  - Transfer at idx==0 in RUN reloads idx=MOD-1 and stays in RUN with valid held high (continuous circular read).
  - done pulses for one cycle in the cycle after each wrap transfer.
  - DONE state is unused; only abort or reset exits RUN.
- Undefined: single-pass behaviour as above.

Decomposition:
- Shared package mb_pkg holds:
  - state enum mb_seq_state_t {IDLE, RUN, DONE};
  - MB_MOD_DEFAULT=13;
  - MB_IDX_W_DEFAULT=4.
- One natural sub-module: mb_down_cnt.
  - Inputs: clk, rst, load, dec.
  - Output: cnt[W-1:0], with load value MOD-1.
  - Output: zero flag.
  - The FSM drives load and dec.

Test Plan:
- Reset: hold rst=0 with random inputs -> idx=0, valid=0, done=0, busy=0, zero=1; after release with no start, all outputs stay unchanged.
- Full pass, ready=1: start pulse at cycle 0 -> valid high cycles 1-13 with idx 12,11,...,0; last=1 only at cycle 13; done=1 at cycle 14 only; busy=0 at cycle 15.
- Backpressure:
  - ready toggling 1,0,0,1,... -> idx holds during each ready=0 cycle.
  - Exactly 13 transfers in order 12..0, no duplicates, done after the 13th transfer.
- Abort:
  - abort at idx=7 together with ready=1 -> next cycle idx=0, valid=0, busy=0, no done pulse.
  - abort and start in the same IDLE cycle -> stays IDLE.
- Start during RUN: second start at idx=5 -> ignored; pass completes normally with a single done pulse.
- MB_DOWN_SEQ_WRAP_EN defined, ready=1: idx sequence 12..0,12..0; valid never drops; done pulses in the cycle after each idx=0 transfer; abort returns to IDLE.

Source files
------------

// File: rtl/mb_pkg.sv
// Shared types and defaults for the reverse read-index sequencer.
package mb_pkg;

    localparam int unsigned MB_MOD_DEFAULT   = 13;
    localparam int unsigned MB_IDX_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mb_seq_state_t;

endpackage

// File: rtl/mb_down_seq_if.sv
// Handshake bundle between the read-index sequencer (master) and its consumer/controller.
interface mb_down_seq_if #(
    parameter int unsigned W = mb_pkg::MB_IDX_W_DEFAULT
);
    logic         start;
    logic         abort;
    logic         ready;
    logic [W-1:0] idx;
    logic         valid;
    logic         last;
    logic         zero;
    logic         done;
    logic         busy;

    modport master (
        input  start, abort, ready,
        output idx, valid, last, zero, done, busy
    );

    modport slave (
        output start, abort, ready,
        input  idx, valid, last, zero, done, busy
    );
endinterface

// File: rtl/mb_down_cnt.sv
// Loadable down-counter holding the read index; clears to 0, reloads to MOD-1, never underflows.
module mb_down_cnt
    import mb_pkg::*;
#(
    parameter int unsigned MOD = MB_MOD_DEFAULT,
    parameter int unsigned W   = MB_IDX_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    localparam logic [W-1:0] RELOAD = W'(MOD - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (dec && !zero) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mb_down_seq.sv
// Reverse read-index sequencer: walks MOD-1..0 under valid/ready, pulses done after index 0.
// Build option MB_DOWN_SEQ_WRAP_EN turns the single pass into a continuous circular read.
module mb_down_seq
    import mb_pkg::*;
#(
    parameter int unsigned MOD = MB_MOD_DEFAULT,
    parameter int unsigned W   = MB_IDX_W_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    mb_down_seq_if.master bus
);

`ifdef MB_DOWN_SEQ_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    if (MOD < 2 || (64'd1 << W) < 64'(MOD)) begin : g_bad_param
        $error("mb_down_seq: MOD must be >= 2 and fit in W bits");
    end

    mb_seq_state_t state;
    mb_seq_state_t state_nxt;

    logic         valid_q;
    logic         done_q;
    logic         valid_nxt;
    logic         done_nxt;
    logic         load;
    logic         dec;
    logic         clr;
    logic         xfer;
    logic [W-1:0] cnt;
    logic         cnt_zero;

    assign xfer = valid_q & bus.ready;

    mb_down_cnt #(
        .MOD (MOD),
        .W   (W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .load (load),
        .dec  (dec),
        .cnt  (cnt),
        .zero (cnt_zero)
    );

    // State register plus the registered valid/done outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            valid_q <= valid_nxt;
            done_q  <= done_nxt;
        end
    end

    // Next-state; abort overrides every other condition
    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) state_nxt = RUN;
                RUN:     if (xfer && cnt_zero && !WRAP_EN) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Counter controls and next values of the registered outputs
    always_comb begin
        load      = 1'b0;
        dec       = 1'b0;
        clr       = 1'b0;
        valid_nxt = 1'b0;
        done_nxt  = 1'b0;
        if (bus.abort) begin
            clr = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        load      = 1'b1;
                        valid_nxt = 1'b1;
                    end
                end
                RUN: begin
                    valid_nxt = 1'b1;
                    if (xfer) begin
                        if (cnt_zero) begin
                            done_nxt = 1'b1;
                            if (WRAP_EN) load      = 1'b1;
                            else         valid_nxt = 1'b0;
                        end else begin
                            dec = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.idx   = cnt;
    assign bus.valid = valid_q;
    assign bus.done  = done_q;
    assign bus.zero  = cnt_zero;
    assign bus.last  = valid_q & cnt_zero;
    assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_mb_down_seq.sv
// Directed bench for mb_down_seq; the wrap scenario replaces single-pass scenarios under MB_DOWN_SEQ_WRAP_EN.
module tb_mb_down_seq;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mb_down_seq_if #(.W(4)) bus ();

    mb_down_seq #(.MOD(13), .W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.start = 1'($urandom);
            bus.abort = 1'($urandom);
            bus.ready = 1'($urandom);
            tick();
            checks++;
            if (bus.idx !== 4'd0 || bus.valid !== 1'b0 || bus.done !== 1'b0 ||
                bus.busy !== 1'b0 || bus.zero !== 1'b1 || bus.last !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold i=%0d: idx=%0d valid=%b done=%b busy=%b zero=%b last=%b, required 0,0,0,0,1,0",
                         i, bus.idx, bus.valid, bus.done, bus.busy, bus.zero, bus.last);
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.ready = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.idx !== 4'd0 || bus.valid !== 1'b0 || bus.done !== 1'b0 ||
                bus.busy !== 1'b0 || bus.zero !== 1'b1) begin
                errors++;
                $display("FAIL reset_release i=%0d: idx=%0d valid=%b done=%b busy=%b zero=%b, required 0,0,0,0,1",
                         i, bus.idx, bus.valid, bus.done, bus.busy, bus.zero);
            end
        end
    endtask

    task automatic test_full_pass();
        idle_inputs();
        bus.start = 1'b1;
        bus.ready = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            checks++;
            if (bus.valid !== 1'b1 || bus.idx !== 4'(13 - c) || bus.last !== (c == 13) ||
                bus.done !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL full_pass c=%0d: valid=%b idx=%0d last=%b done=%b busy=%b, required 1,%0d,%b,0,1",
                         c, bus.valid, bus.idx, bus.last, bus.done, bus.busy, 13 - c, (c == 13));
            end
            tick();
        end
        checks++;
        if (bus.done !== 1'b1 || bus.valid !== 1'b0 || bus.busy !== 1'b1 || bus.idx !== 4'd0) begin
            errors++;
            $display("FAIL full_pass_done: done=%b valid=%b busy=%b idx=%0d, required 1,0,1,0",
                     bus.done, bus.valid, bus.busy, bus.idx);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL full_pass_idle: done=%b busy=%b valid=%b, required 0,0,0",
                     bus.done, bus.busy, bus.valid);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_idx;
        logic       exp_valid;
        logic       r;
        int         n;
        bit         seen_done;
        idle_inputs();
        exp_idx   = 4'd12;
        exp_valid = 1'b1;
        n         = 0;
        seen_done = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 80 && !seen_done; k++) begin
            checks++;
            if (exp_valid) begin
                if (bus.valid !== 1'b1 || bus.idx !== exp_idx || bus.done !== 1'b0) begin
                    errors++;
                    $display("FAIL backpressure k=%0d: valid=%b idx=%0d done=%b, required 1,%0d,0",
                             k, bus.valid, bus.idx, bus.done, exp_idx);
                end
            end else begin
                seen_done = 1'b1;
                if (bus.done !== 1'b1 || bus.valid !== 1'b0) begin
                    errors++;
                    $display("FAIL backpressure_done: done=%b valid=%b, required 1,0",
                             bus.done, bus.valid);
                end
            end
            r = (k % 3 == 0);
            bus.ready = r;
            tick();
            if (r && exp_valid) begin
                n++;
                if (exp_idx == 4'd0) exp_valid = 1'b0;
                else                 exp_idx   = exp_idx - 4'd1;
            end
        end
        bus.ready = 1'b0;
        checks++;
        if (n != 13 || !seen_done) begin
            errors++;
            $display("FAIL backpressure_count: transfers=%0d done_seen=%0d, required 13,1", n, seen_done);
        end
    endtask

    task automatic test_start_during_run();
        int dones;
        idle_inputs();
        dones = 0;
        bus.start = 1'b1;
        bus.ready = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (bus.done === 1'b1) dones++;
            if (c <= 13) begin
                checks++;
                if (bus.valid !== 1'b1 || bus.idx !== 4'(13 - c)) begin
                    errors++;
                    $display("FAIL start_in_run c=%0d: valid=%b idx=%0d, required 1,%0d",
                             c, bus.valid, bus.idx, 13 - c);
                end
            end
            if (c == 14) begin
                checks++;
                if (bus.done !== 1'b1) begin
                    errors++;
                    $display("FAIL start_in_run_done: done=%b, required 1", bus.done);
                end
            end
            bus.start = (c == 8);
            tick();
        end
        bus.start = 1'b0;
        checks++;
        if (dones != 1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_run_pulses: dones=%0d busy=%b, required 1,0", dones, bus.busy);
        end
    endtask

    task automatic test_abort();
        idle_inputs();
        bus.start = 1'b1;
        bus.ready = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        checks++;
        if (bus.idx !== 4'd7 || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: idx=%0d valid=%b, required 7,1", bus.idx, bus.valid);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if (bus.idx !== 4'd0 || bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort: idx=%0d valid=%b busy=%b done=%b, required 0,0,0,0",
                     bus.idx, bus.valid, bus.busy, bus.done);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_after: done=%b busy=%b valid=%b, required 0,0,0",
                     bus.done, bus.busy, bus.valid);
        end
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.idx !== 4'd0) begin
            errors++;
            $display("FAIL abort_with_start: busy=%b valid=%b idx=%0d, required 0,0,0",
                     bus.busy, bus.valid, bus.idx);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_with_start_after: busy=%b valid=%b, required 0,0", bus.busy, bus.valid);
        end
    endtask

    task automatic test_reset_mid_pass();
        idle_inputs();
        bus.start = 1'b1;
        bus.ready = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 4; c++) tick();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.idx !== 4'd0 || bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pass: idx=%0d valid=%b busy=%b zero=%b, required 0,0,0,1",
                     bus.idx, bus.valid, bus.busy, bus.zero);
        end
        tick();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_pass_after c=%0d: done=%b busy=%b valid=%b, required 0,0,0",
                         c, bus.done, bus.busy, bus.valid);
            end
        end
        bus.ready = 1'b0;
    endtask

`ifdef MB_DOWN_SEQ_WRAP_EN
    task automatic test_wrap();
        idle_inputs();
        bus.start = 1'b1;
        bus.ready = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 27; c++) begin
            checks++;
            if (bus.valid !== 1'b1 || bus.idx !== 4'(12 - ((c - 1) % 13)) ||
                bus.done !== (c == 14 || c == 27)) begin
                errors++;
                $display("FAIL wrap c=%0d: valid=%b idx=%0d done=%b, required 1,%0d,%b",
                         c, bus.valid, bus.idx, bus.done, 12 - ((c - 1) % 13), (c == 14 || c == 27));
            end
            tick();
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.ready = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.idx !== 4'd0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL wrap_abort: busy=%b valid=%b idx=%0d done=%b, required 0,0,0,0",
                     bus.busy, bus.valid, bus.idx, bus.done);
        end
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.ready = 1'b0;
        test_reset();
`ifdef MB_DOWN_SEQ_WRAP_EN
        test_wrap();
`else
        test_full_pass();
        test_backpressure();
        test_start_during_run();
`endif
        test_abort();
        test_reset_mid_pass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
